// File: rtl/apb_slave_decoder.sv
// rtl/apb_slave_decoder.sv - registered APB decoder replaying one upstream transfer to one of NUM_SLAVES slaves
module apb_slave_decoder #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SEL_LSB    = 12,
    parameter int BASE       = 0,
    parameter int TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_psel,
    input  logic                         s_penable,
    input  logic                         s_pwrite,
    input  logic [ADDR_W-1:0]            s_paddr,
    input  logic [DATA_W-1:0]            s_pwdata,
    output logic                         s_pready,
    output logic [DATA_W-1:0]            s_prdata,
    output logic                         s_pslverr,
    output logic [NUM_SLAVES-1:0]        m_psel,
    output logic                         m_penable,
    output logic                         m_pwrite,
    output logic [SEL_LSB-1:0]           m_paddr,
    output logic [DATA_W-1:0]            m_pwdata,
    input  logic [NUM_SLAVES-1:0]        m_pready,
    input  logic [NUM_SLAVES-1:0]        m_pslverr,
    input  logic [NUM_SLAVES*DATA_W-1:0] m_prdata,
    output logic [7:0]                   err_count
);

    localparam int HI_W  = ADDR_W - SEL_LSB - 3;
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, ERR} state_t;

    state_t              state;
    state_t              state_next;
    logic [SEL_LSB-1:0]  addr_q;
    logic [2:0]          idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                write_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                slverr_q;
    logic [CNT_W-1:0]    cnt;
    logic [7:0]          err_q;

    logic                start;
    logic [2:0]          s_idx;
    logic                mapped;
    logic                sel_ready;
    logic                sel_err;
    logic [DATA_W-1:0]   sel_rdata;
    logic                timeout_hit;
    logic                local_err;

    assign start       = s_psel && !s_penable;
    assign s_idx       = s_paddr[SEL_LSB+2:SEL_LSB];
    assign mapped      = (s_paddr[ADDR_W-1:SEL_LSB+3] == HI_W'(BASE)) && (32'(s_idx) < NUM_SLAVES);
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // Slave response mux; idx_q is always in range whenever ACCESS is reached.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == 3'(i)) begin
                sel_ready = m_pready[i];
                sel_err   = m_pslverr[i];
                sel_rdata = m_prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready beats the timeout when both land in the same cycle.
    assign local_err = (state == ERR) || ((state == ACCESS) && !sel_ready && timeout_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = mapped ? SETUP : ERR;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (sel_ready || timeout_hit) state_next = RESP;
            ERR:     state_next = RESP;
            RESP:    if (s_psel && s_penable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
            cnt      <= '0;
            err_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q  <= s_paddr[SEL_LSB-1:0];
                        idx_q   <= s_idx;
                        wdata_q <= s_pwdata;
                        write_q <= s_pwrite;
                    end
                end
                SETUP: cnt <= '0;
                ACCESS: begin
                    if (sel_ready) begin
                        rdata_q  <= sel_rdata;
                        slverr_q <= sel_err;
                    end else if (timeout_hit) begin
                        rdata_q  <= '0;
                        slverr_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERR: begin
                    rdata_q  <= '0;
                    slverr_q <= 1'b1;
                end
                default: ;
            endcase
            if (local_err && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    always_comb begin
        s_pready  = (state == RESP) && s_psel && s_penable;
        s_prdata  = s_pready ? rdata_q : '0;
        s_pslverr = s_pready && slverr_q;
        m_psel    = '0;
        if ((state == SETUP) || (state == ACCESS)) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                m_psel[i] = (idx_q == 3'(i));
            end
        end
        m_penable = (state == ACCESS);
        m_pwrite  = write_q;
        m_paddr   = addr_q;
        m_pwdata  = wdata_q;
    end

    assign err_count = err_q;

endmodule

// File: tb/tb_apb_slave_decoder.sv
// tb/tb_apb_slave_decoder.sv - randomized self-checking bench for apb_slave_decoder
module tb_apb_slave_decoder;

    localparam int NS = 4;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_psel, s_penable, s_pwrite;
    logic [31:0]       s_paddr, s_pwdata;
    logic              s_pready, s_pslverr;
    logic [31:0]       s_prdata;
    logic [NS-1:0]     m_psel;
    logic              m_penable, m_pwrite;
    logic [11:0]       m_paddr;
    logic [31:0]       m_pwdata;
    logic [NS-1:0]     m_pready, m_pslverr;
    logic [NS*32-1:0]  m_prdata;
    logic [7:0]        err_count;

    int checks = 0;
    int errors = 0;

    // Slave behaviour knobs and storage.
    int          wait_cfg [NS];
    logic        err_cfg  [NS];
    int          acc_cnt  [NS];
    logic [31:0] mem      [NS][16];

    // Reference model state.
    logic [31:0] ref_mem  [NS][16];
    int          ref_errs;

    always #5 clk = ~clk;

    apb_slave_decoder dut (
        .clk(clk), .rst(rst),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata),
        .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
        .err_count(err_count)
    );

    always_comb begin
        m_pready  = '0;
        m_pslverr = '0;
        m_prdata  = '0;
        for (int i = 0; i < NS; i++) begin
            m_pready[i]         = m_psel[i] && m_penable && (acc_cnt[i] >= wait_cfg[i]);
            m_pslverr[i]        = m_pready[i] && err_cfg[i];
            m_prdata[i*32 +: 32] = mem[i][m_paddr[5:2]];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (rst) begin
                acc_cnt[i] <= 0;
                for (int j = 0; j < 16; j++) mem[i][j] <= 32'hA000_0000 | (i << 8) | j;
            end else begin
                acc_cnt[i] <= (m_psel[i] && m_penable) ? acc_cnt[i] + 1 : 0;
                if (m_pready[i] && m_pwrite) mem[i][m_paddr[5:2]] <= m_pwdata;
            end
        end
    end

    task automatic ref_reset();
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < 16; j++) ref_mem[i][j] = 32'hA000_0000 | (i << 8) | j;
        ref_errs = 0;
    endtask

    // Transfer outcome derived from the decode rules: window, select field, wait states, timeout.
    task automatic model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] d, output logic e, output int lat, output int acc);
        int idx;
        idx = int'(addr[14:12]);
        if (addr[31:15] != 0 || idx >= NS) begin
            d = 0; e = 1; lat = 2; acc = 0;
            if (ref_errs < 255) ref_errs++;
        end else if (wait_cfg[idx] >= TO) begin
            d = 0; e = 1; lat = 2 + TO; acc = TO;
            if (ref_errs < 255) ref_errs++;
        end else begin
            d = ref_mem[idx][addr[5:2]]; e = err_cfg[idx];
            lat = 3 + wait_cfg[idx]; acc = wait_cfg[idx] + 1;
            if (wr) ref_mem[idx][addr[5:2]] = wdata;
        end
    endtask

    // Upstream master: setup at cycle 0, access from cycle 1, returns the cycle s_pready was seen.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int nsetup, output int nacc, output logic [NS-1:0] psel_or,
                        output logic [11:0] paddr_seen, output logic proto_ok);
        @(negedge clk);
        s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr; s_paddr = addr; s_pwdata = wdata;
        lat = 0; nsetup = 0; nacc = 0; psel_or = '0; paddr_seen = '0; proto_ok = 1'b1;
        rdata = '0; err = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            s_penable = 1'b1;
            #1;
            if (m_psel != 0) begin
                psel_or = psel_or | m_psel;
                paddr_seen = m_paddr;
                if (m_penable) nacc++; else nsetup++;
                if (m_paddr !== addr[11:0] || m_pwdata !== wdata || m_pwrite !== wr) proto_ok = 1'b0;
            end else if (m_penable) begin
                proto_ok = 1'b0;
            end
            if (s_pready) begin
                lat = c; rdata = s_prdata; err = s_pslverr;
                break;
            end
            if (s_prdata !== 0 || s_pslverr !== 1'b0) proto_ok = 1'b0;
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL xfer_hang addr=%h no s_pready within 60 cycles", addr);
            s_psel = 1'b0; s_penable = 1'b0;
        end
    endtask

    task automatic idle_bus();
        @(negedge clk);
        s_psel = 1'b0; s_penable = 1'b0;
    endtask

    logic [31:0]   rd, ed;
    logic          er, ee, ok;
    int            lat, el, ns, na, ea;
    logic [NS-1:0] po;
    logic [11:0]   pa;

    task automatic test_reset();
        rst = 1'b1;
        s_psel = 0; s_penable = 0; s_pwrite = 0; s_paddr = 0; s_pwdata = 0;
        for (int i = 0; i < NS; i++) begin wait_cfg[i] = 0; err_cfg[i] = 1'b0; end
        ref_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({s_pready, s_pslverr, m_penable, m_pwrite} !== 4'b0) begin errors++; $display("FAIL rst_ctrl got %b exp 0000", {s_pready, s_pslverr, m_penable, m_pwrite}); end
        checks++; if (m_psel !== '0 || m_paddr !== '0 || m_pwdata !== '0 || s_prdata !== '0) begin errors++; $display("FAIL rst_data got psel=%b paddr=%h pwdata=%h prdata=%h exp 0", m_psel, m_paddr, m_pwdata, s_prdata); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_errcnt got %0d exp 0", err_count); end
        rst = 1'b0;
    endtask

    task automatic test_mapped_write();
        wait_cfg[1] = 0;
        model(1'b1, 32'h0000_1010, 32'hDEAD_BEEF, ed, ee, el, ea);
        xfer(1'b1, 32'h0000_1010, 32'hDEAD_BEEF, rd, er, lat, ns, na, po, pa, ok);
        checks++; if (po !== 4'b0010) begin errors++; $display("FAIL wr_psel got %b exp 0010", po); end
        checks++; if (pa !== 12'h010) begin errors++; $display("FAIL wr_paddr got %h exp 010", pa); end
        checks++; if (ns !== 1 || na !== 1) begin errors++; $display("FAIL wr_phases got setup=%0d access=%0d exp 1/1", ns, na); end
        checks++; if (lat !== 3 || er !== 1'b0) begin errors++; $display("FAIL wr_resp got lat=%0d err=%b exp 3/0", lat, er); end
        checks++; if (!ok) begin errors++; $display("FAIL wr_stable got unstable exp stable"); end
        idle_bus();
        checks++; if (mem[1][4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_delivered got %h exp deadbeef", mem[1][4]); end
    endtask

    task automatic test_read_wait();
        wait_cfg[3] = 0;
        model(1'b1, 32'h0000_3004, 32'h1234_5678, ed, ee, el, ea);
        xfer(1'b1, 32'h0000_3004, 32'h1234_5678, rd, er, lat, ns, na, po, pa, ok);
        wait_cfg[3] = 2;
        model(1'b0, 32'h0000_3004, 32'h0, ed, ee, el, ea);
        xfer(1'b0, 32'h0000_3004, 32'h0, rd, er, lat, ns, na, po, pa, ok);
        checks++; if (lat !== 5 || na !== 3) begin errors++; $display("FAIL rdw_latency got lat=%0d access=%0d exp 5/3", lat, na); end
        checks++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin errors++; $display("FAIL rdw_data got %h err=%b exp 12345678/0", rd, er); end
        checks++; if (po !== 4'b1000 || !ok) begin errors++; $display("FAIL rdw_psel got %b ok=%b exp 1000/1", po, ok); end
        idle_bus();
    endtask

    task automatic test_unmapped();
        model(1'b0, 32'h0000_5000, 32'h0, ed, ee, el, ea);
        xfer(1'b0, 32'h0000_5000, 32'h0, rd, er, lat, ns, na, po, pa, ok);
        checks++; if (po !== '0 || m_penable !== 1'b0) begin errors++; $display("FAIL unm_psel got %b exp 0000", po); end
        checks++; if (lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL unm_resp got lat=%0d err=%b data=%h exp 2/1/0", lat, er, rd); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL unm_errcnt got %0d exp 1", err_count); end
        model(1'b1, 32'h0001_0000, 32'h55, ed, ee, el, ea);
        xfer(1'b1, 32'h0001_0000, 32'h55, rd, er, lat, ns, na, po, pa, ok);
        checks++; if (po !== '0 || lat !== 2 || er !== 1'b1 || err_count !== 8'd2) begin errors++; $display("FAIL unm_base got psel=%b lat=%0d err=%b cnt=%0d exp 0/2/1/2", po, lat, er, err_count); end
        idle_bus();
    endtask

    task automatic test_timeout();
        wait_cfg[0] = 255;
        model(1'b0, 32'h0000_0008, 32'h0, ed, ee, el, ea);
        xfer(1'b0, 32'h0000_0008, 32'h0, rd, er, lat, ns, na, po, pa, ok);
        checks++; if (na !== TO || lat !== TO + 2) begin errors++; $display("FAIL to_cycles got access=%0d lat=%0d exp %0d/%0d", na, lat, TO, TO + 2); end
        checks++; if (er !== 1'b1 || rd !== 32'h0 || err_count !== 8'(ref_errs)) begin errors++; $display("FAIL to_resp got err=%b data=%h cnt=%0d exp 1/0/%0d", er, rd, err_count, ref_errs); end
        wait_cfg[0] = TO - 1;
        model(1'b0, 32'h0000_000C, 32'h0, ed, ee, el, ea);
        xfer(1'b0, 32'h0000_000C, 32'h0, rd, er, lat, ns, na, po, pa, ok);
        checks++; if (na !== TO || er !== 1'b0 || rd !== 32'hA000_0003) begin errors++; $display("FAIL to_edge got access=%0d err=%b data=%h exp %0d/0/a0000003", na, er, rd, TO); end
        checks++; if (err_count !== 8'(ref_errs)) begin errors++; $display("FAIL to_edge_cnt got %0d exp %0d", err_count, ref_errs); end
        idle_bus();
    endtask

    task automatic test_random();
        logic [31:0] a, w;
        logic        wr;
        int          sel, i;
        int          waits [6] = '{0, 1, 2, 3, 15, 20};
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            i   = $urandom_range(0, NS - 1);
            if (sel < 7)       a = {17'h0, 3'(i), 12'($urandom)};
            else if (sel == 7) a = {17'h0, 3'($urandom_range(NS, 7)), 12'($urandom)};
            else               a = $urandom | 32'h0001_0000;
            wr = 1'($urandom);
            w  = $urandom;
            wait_cfg[i] = waits[$urandom_range(0, 5)];
            err_cfg[i]  = ($urandom_range(0, 3) == 0);
            model(wr, a, w, ed, ee, el, ea);
            xfer(wr, a, w, rd, er, lat, ns, na, po, pa, ok);
            checks++;
            if (lat !== el || rd !== ed || er !== ee || na !== ea || !ok || err_count !== 8'(ref_errs)) begin
                errors++;
                $display("FAIL rand[%0d] addr=%h got lat=%0d data=%h err=%b acc=%0d ok=%b cnt=%0d exp %0d/%h/%b/%0d/1/%0d",
                         n, a, lat, rd, er, na, ok, err_count, el, ed, ee, ea, ref_errs);
            end
        end
        idle_bus();
        for (int k = 0; k < NS; k++) begin wait_cfg[k] = 0; err_cfg[k] = 1'b0; end
    endtask

    task automatic test_saturation();
        int bad = 0;
        for (int n = 0; n < 260; n++) begin
            model(1'b0, 32'h0000_5000 + n, 32'h0, ed, ee, el, ea);
            xfer(1'b0, 32'h0000_5000 + n, 32'h0, rd, er, lat, ns, na, po, pa, ok);
            if (er !== 1'b1 || lat !== 2) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL sat_resp got %0d bad responses exp 0", bad); end
        checks++; if (err_count !== 8'd255 || ref_errs != 255) begin errors++; $display("FAIL sat_count got %0d exp 255", err_count); end
        err_cfg[2] = 1'b1;
        model(1'b0, 32'h0000_2000, 32'h0, ed, ee, el, ea);
        xfer(1'b0, 32'h0000_2000, 32'h0, rd, er, lat, ns, na, po, pa, ok);
        checks++; if (er !== 1'b1 || rd !== 32'hA000_0200 || lat !== 3 || err_count !== 8'd255) begin errors++; $display("FAIL slverr_pass got err=%b data=%h lat=%0d cnt=%0d exp 1/a0000200/3/255", er, rd, lat, err_count); end
        err_cfg[2] = 1'b0;
        idle_bus();
    endtask

    task automatic test_reset_mid();
        wait_cfg[1] = 255;
        @(negedge clk);
        s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = 32'h0000_1000;
        @(negedge clk); s_penable = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (m_penable !== 1'b1 || m_psel !== 4'b0010) begin errors++; $display("FAIL rm_inaccess got psel=%b en=%b exp 0010/1", m_psel, m_penable); end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++; if (m_psel !== '0 || m_penable !== 1'b0 || s_pready !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL rm_dropped got psel=%b en=%b rdy=%b cnt=%0d exp 0/0/0/0", m_psel, m_penable, s_pready, err_count); end
        rst = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
        ref_reset();
        wait_cfg[1] = 0;
        model(1'b0, 32'h0000_1008, 32'h0, ed, ee, el, ea);
        xfer(1'b0, 32'h0000_1008, 32'h0, rd, er, lat, ns, na, po, pa, ok);
        checks++; if (lat !== 3 || rd !== 32'hA000_0102 || er !== 1'b0 || ns !== 1) begin errors++; $display("FAIL rm_after got lat=%0d data=%h err=%b setup=%0d exp 3/a0000102/0/1", lat, rd, er, ns); end
        idle_bus();
    endtask

    initial begin
        test_reset();
        test_mapped_write();
        test_read_wait();
        test_unmapped();
        test_timeout();
        test_random();
        test_saturation();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
